// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with framing strobes and running mod-3 residue.
// Latency: bit 0 on dout the cycle after accept when idle; div3 result one cycle after the last bit.
// Backpressure: one-entry hold register; din_ready = ~hold_full, hold drains gaplessly at frame end.
module serial_word_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             div3_valid,
    output logic             div3,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [1:0]       res;
    logic [1:0]       res_nxt;
    logic [1:0]       bit_term;
    logic             active;
    logic             last_bit;
    logic             shifter_free;
    logic             accept;
    logic             load_hold;
    logic             load_din;
    logic             to_hold;

    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    always_comb begin
        active       = (state == S_SHIFT);
        last_bit     = active && (cnt == LAST_IDX);
        // Shifter can take a new word while idle or while presenting its final bit.
        shifter_free = !active || last_bit;
        accept       = din_valid && !hold_full;
        load_hold    = last_bit && hold_full;
        load_din     = accept && shifter_free;
        to_hold      = accept && !shifter_free;
        // Bit i carries weight 2^i mod 3: 1 on even positions, 2 on odd.
        bit_term     = !dout ? 2'd0 : (cnt[0] ? 2'd2 : 2'd1);
        res_nxt      = add_mod3(res, bit_term);
    end

    always_comb begin
        state_nxt = state;
        if (load_hold || load_din) begin
            state_nxt = S_SHIFT;
        end else if (last_bit) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg       <= '0;
            cnt        <= '0;
            res        <= 2'd0;
            hold       <= '0;
            hold_full  <= 1'b0;
            div3_valid <= 1'b0;
            div3       <= 1'b0;
        end else begin
            div3_valid <= last_bit;
            if (last_bit) begin
                div3 <= (res_nxt == 2'd0);
            end

            if (load_hold) begin
                sreg <= hold;
                cnt  <= '0;
                res  <= 2'd0;
            end else if (load_din) begin
                sreg <= din;
                cnt  <= '0;
                res  <= 2'd0;
            end else if (active) begin
                sreg <= sreg >> 1;
                cnt  <= last_bit ? '0 : cnt + 1'b1;
                res  <= last_bit ? 2'd0 : res_nxt;
            end

            if (load_hold) begin
                hold_full <= 1'b0;
            end else if (to_hold) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
        end
    end

    assign din_ready   = ~hold_full;
    assign dout        = active & sreg[0];
    assign dout_valid  = active;
    assign frame_start = active & (cnt == '0);
    assign frame_last  = last_bit;
    assign busy        = active | hold_full;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx at WIDTH=8: framing, div3 results, streaming, reset, backpressure.
module tb_serial_word_tx;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       dout_valid;
    logic       frame_start;
    logic       frame_last;
    logic       div3_valid;
    logic       div3;
    logic       busy;

    int n_cmp;
    int n_err;

    logic [7:0] wq [0:255];

    serial_word_tx #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .div3_valid  (div3_valid),
        .div3        (div3),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents wq[0..n-1] under valid/ready; entered and left at a negedge.
    task automatic src_stream(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            din       = wq[k];
            din_valid = 1'b1;
            guard     = 0;
            while (din_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL src_timeout word=%0d din_ready=%b required=1", k, din_ready);
            end
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        reset     = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        #2;
        obs = {dout, dout_valid, frame_start, frame_last, div3_valid, div3, busy, din_ready};
        n_cmp++;
        if (obs !== 8'b0000_0001) begin
            n_err++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 8'b0000_0001);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        obs = {dout, dout_valid, frame_start, frame_last, div3_valid, div3, busy, din_ready};
        n_cmp++;
        if (obs !== 8'b0000_0001) begin
            n_err++;
            $display("FAIL reset_release got=%b exp=%b", obs, 8'b0000_0001);
        end
    endtask

    task automatic test_single_word(input logic [7:0] w);
        logic [5:0] obs;
        logic [5:0] exp;
        logic [2:0] robs;
        logic [2:0] rexp;
        n_cmp++;
        if (din_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready w=%h got=%b exp=1", w, din_ready);
        end
        din       = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din       = ~w;
        for (int i = 0; i < 8; i++) begin
            obs = {dout, dout_valid, frame_start, frame_last, div3_valid, busy};
            exp = {w[i], 1'b1, (i == 0), (i == 7), 1'b0, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL single_bit w=%h i=%0d got=%b exp=%b", w, i, obs, exp);
            end
            @(negedge clk);
        end
        robs = {div3_valid, div3, dout_valid};
        rexp = {1'b1, (w % 3 == 0), 1'b0};
        n_cmp++;
        if (robs !== rexp) begin
            n_err++;
            $display("FAIL single_div3 w=%h got=%b exp=%b", w, robs, rexp);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] got;
        logic        gap_bad;
        logic        frm_bad;
        wq[0] = 8'h03;
        wq[1] = 8'h05;
        wq[2] = 8'h09;
        gap_bad = 1'b0;
        frm_bad = 1'b0;
        got     = '0;
        fork
            src_stream(3);
            begin
                @(negedge clk);
                for (int c = 0; c < 24; c++) begin
                    got[c]  = dout;
                    gap_bad = gap_bad | (dout_valid !== 1'b1);
                    frm_bad = frm_bad | (frame_start !== (c % 8 == 0)) | (frame_last !== (c % 8 == 7));
                    if (c == 1) begin
                        n_cmp++;
                        if (din_ready !== 1'b0) begin
                            n_err++;
                            $display("FAIL b2b_ready_low got=%b exp=0", din_ready);
                        end
                    end
                    if (c == 8 || c == 16) begin
                        n_cmp++;
                        if ({div3_valid, div3} !== {1'b1, (c == 8)}) begin
                            n_err++;
                            $display("FAIL b2b_div3 c=%0d got=%b%b exp=1%b", c, div3_valid, div3, (c == 8));
                        end
                    end
                    @(negedge clk);
                end
                n_cmp++;
                if ({div3_valid, div3, dout_valid} !== 3'b110) begin
                    n_err++;
                    $display("FAIL b2b_div3_last got=%b%b%b exp=110", div3_valid, div3, dout_valid);
                end
            end
        join
        n_cmp++;
        if (got !== 24'h090503) begin
            n_err++;
            $display("FAIL b2b_stream got=%h exp=%h", got, 24'h090503);
        end
        n_cmp++;
        if ({gap_bad, frm_bad} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_framing gap=%b frame=%b exp=00", gap_bad, frm_bad);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] rebuilt;
        logic       frm_bad;
        for (int k = 0; k < 256; k++) wq[k] = 8'(k);
        fork
            src_stream(256);
            begin
                @(negedge clk);
                for (int k = 0; k < 256; k++) begin
                    frm_bad = 1'b0;
                    rebuilt = '0;
                    for (int i = 0; i < 8; i++) begin
                        rebuilt[i] = dout;
                        frm_bad = frm_bad | (dout_valid !== 1'b1) | (frame_start !== (i == 0))
                                  | (frame_last !== (i == 7)) | (div3_valid !== (i == 0 && k > 0));
                        if (i == 0 && k > 0) begin
                            n_cmp++;
                            if (div3 !== ((k - 1) % 3 == 0)) begin
                                n_err++;
                                $display("FAIL exh_div3 value=%0d got=%b exp=%b", k - 1, div3, ((k - 1) % 3 == 0));
                            end
                        end
                        @(negedge clk);
                    end
                    n_cmp++;
                    if (rebuilt !== 8'(k) || frm_bad !== 1'b0) begin
                        n_err++;
                        $display("FAIL exh_word value=%0d got=%h framing_bad=%b", k, rebuilt, frm_bad);
                    end
                end
                n_cmp++;
                if ({div3_valid, div3} !== 2'b11) begin
                    n_err++;
                    $display("FAIL exh_div3 value=255 got=%b%b exp=11", div3_valid, div3);
                end
            end
        join
    endtask

    task automatic test_reset_midframe();
        logic [5:0] obs;
        logic [7:0] robs;
        logic       quiet_bad;
        din       = 8'h0C;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h55;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        obs = {dout, dout_valid, frame_start, frame_last, busy, din_ready};
        n_cmp++;
        if (obs !== 6'b010010) begin
            n_err++;
            $display("FAIL rst_mid_before got=%b exp=%b", obs, 6'b010010);
        end
        reset = 1'b1;
        #1;
        robs = {dout, dout_valid, frame_start, frame_last, div3_valid, div3, busy, din_ready};
        n_cmp++;
        if (robs !== 8'b0000_0001) begin
            n_err++;
            $display("FAIL rst_mid_async got=%b exp=%b", robs, 8'b0000_0001);
        end
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        quiet_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            quiet_bad = quiet_bad | (dout_valid !== 1'b0) | (div3_valid !== 1'b0) | (din_ready !== 1'b1);
            @(negedge clk);
        end
        n_cmp++;
        if (quiet_bad !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_quiet got=%b exp=0", quiet_bad);
        end
        test_single_word(8'h0C);
    endtask

    task automatic test_backpressure();
        logic [23:0] got;
        logic        gap_bad;
        logic        rdy_bad;
        logic        guard_hit;
        int          guard;
        gap_bad   = 1'b0;
        rdy_bad   = 1'b0;
        guard_hit = 1'b0;
        got       = '0;
        fork
            begin
                din       = 8'h11;
                din_valid = 1'b1;
                @(negedge clk);
                din = 8'h22;
                @(negedge clk);
                din       = 8'hEE;
                din_valid = 1'b0;
                @(negedge clk);
                din       = 8'h33;
                din_valid = 1'b1;
                guard     = 0;
                while (din_ready !== 1'b1 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                guard_hit = (guard >= 100);
                @(negedge clk);
                din_valid = 1'b0;
                din       = 8'hEE;
            end
            begin
                @(negedge clk);
                for (int c = 0; c < 24; c++) begin
                    got[c]  = dout;
                    gap_bad = gap_bad | (dout_valid !== 1'b1);
                    if (c >= 1 && c <= 7) rdy_bad = rdy_bad | (din_ready !== 1'b0);
                    if (c == 8) begin
                        n_cmp++;
                        if (din_ready !== 1'b1) begin
                            n_err++;
                            $display("FAIL bp_ready_rise got=%b exp=1", din_ready);
                        end
                    end
                    @(negedge clk);
                end
            end
        join
        n_cmp++;
        if ({rdy_bad, guard_hit} !== 2'b00) begin
            n_err++;
            $display("FAIL bp_ready_low ready_bad=%b timeout=%b exp=00", rdy_bad, guard_hit);
        end
        n_cmp++;
        if (got !== 24'h332211 || gap_bad !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stream got=%h gap=%b exp=%h gap=0", got, gap_bad, 24'h332211);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_word(8'h06);
        test_single_word(8'h07);
        test_single_word(8'h00);
        test_single_word(8'hFF);
        test_back_to_back();
        @(negedge clk);
        test_exhaustive();
        @(negedge clk);
        test_reset_midframe();
        @(negedge clk);
        test_backpressure();
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial transmitter that produces the single-bit stream consumed by the team's serial divisibility-by-3 checker. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out LSB-first, one bit per clock, with framing strobes. It also tracks the running mod-3 residue of the bits sent, so benches can compare against the checker directly. It sits between a word source (test sequencer or datapath) and any serial bit-stream consumer.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  WIDTH  word to transmit; sampled on accept.
- din_valid  in  1  source has a word on din.
- din_ready  out  1  block can take a word (holding register empty).
- dout  out  1  serial data bit; LSB of the word first.
- dout_valid  out  1  dout carries a live bit this cycle.
- frame_start  out  1  high with bit 0 of each word.
- frame_last  out  1  high with bit WIDTH-1 of each word.
- div3_valid  out  1  one-cycle pulse, the cycle after frame_last.
- div3  out  1  with div3_valid: 1 if the word just sent is divisible by 3.
- busy  out  1  shifter active or holding register full.

## Operation
- Storage: a one-entry holding register (hold, hold_full), a shift register (sreg), a bit counter (cnt, width clog2(WIDTH)), a residue register (res[1:0]), and an active flag.
- Accept: din_valid & din_ready at a rising edge. din_ready = ~hold_full (combinational; no dependency on din_valid).
- On accept, the word goes straight into sreg if the shifter is free at that edge, meaning it is idle or presenting bit WIDTH-1 this cycle. Otherwise the word goes into hold.
- On the edge that ends bit WIDTH-1: if hold_full, load sreg from hold and clear hold_full, giving a gapless next frame. Else, if an accept occurs on this edge, load sreg from din. Else, the shifter goes idle.
- Shifting: dout = sreg[0]; each active edge shifts sreg right by one and increments cnt. cnt wraps to 0 on a new load.
- Outputs: frame_start = active & (cnt==0); frame_last = active & (cnt==WIDTH-1); dout_valid = active.
- Residue: res resets to 0 at each frame load. For bit i, weight = 1 if i is even, 2 if i is odd (2^i mod 3). On each active edge, res <= (res + dout*weight) mod 3. All arithmetic is 2-bit modulo 3.
- Result: on the edge ending frame_last, register div3 = ((res + dout*weight_last) mod 3 == 0) and pulse div3_valid for one cycle. div3 holds its value until the next pulse.
- Simultaneous events: an accept on the last-bit edge while hold is empty loads sreg directly. hold then stays empty and din_ready stays 1.
- Reset, asynchronous at any time including mid-frame: the partial word and the held word are discarded.
  - active, hold_full, cnt, res, sreg are cleared.
  - dout, dout_valid, frame_start, frame_last, div3_valid, div3, busy are all 0.
  - din_ready is 1.
  - No div3_valid pulse is produced for an aborted frame.

## Timing
- Latency: word accepted at edge E while idle → bit 0 on dout (frame_start=1) in the cycle following E. Bit WIDTH-1 appears in cycle E+WIDTH. div3_valid appears in cycle E+WIDTH+1.
- Throughput: one word per WIDTH cycles sustained, with zero idle cycles between back-to-back frames.
- div3_valid of frame k coincides with frame_start of frame k+1 when streaming.
- din_ready drops the cycle after an accept lands in hold. It rises the cycle after hold drains into sreg.
- All outputs except din_ready are registered or decoded from registers only. There is no combinational path from din or din_valid to dout.

## Test plan
- Single word, WIDTH=8, din=0x06 while idle → dout sequence 0,1,1,0,0,0,0,0 over 8 cycles starting the cycle after accept. frame_start on the 1st cycle, frame_last on the 8th. div3_valid=1 with div3=1 on the 9th cycle.
- din=0x07 → dout 1,1,1,0,0,0,0,0; div3=0. din=0x00 → div3=1. din=0xFF → div3=1 (255=3·85).
- Back-to-back: din_valid held high with 0x03, 0x05, 0x09 → 24 consecutive dout_valid cycles with no gaps. din_ready low while hold is full. div3 sequence 1,0,1.
- Exhaustive: all 256 values streamed → div3 matches (value % 3 == 0) and res matches a reference model bit-by-bit. Output cross-checked against the serial divisibility checker fed from dout.
- Reset mid-frame: assert reset at bit 4 of 0x0C with another word held → all outputs 0 immediately, din_ready=1, no div3_valid. A fresh word after reset release transmits correctly.
- Backpressure: din_valid asserted while hold is full → no accept and din is ignored until din_ready rises. The word is then transmitted intact.
